// File: rtl/vga_test_pattern_gen.sv
// vga_test_pattern_gen: synthetic camera source producing VSYNC/HREF frames with selectable byte patterns.
// All outputs are registered one cycle behind the state/counter registers.
module vga_test_pattern_gen #(
   parameter int H_ACTIVE_BYTES = 640,
   parameter int H_BLANK        = 16,
   parameter int V_ACTIVE_LINES = 240,
   parameter int VSYNC_LINES    = 2,
   parameter int V_BACK_LINES   = 2,
   parameter int V_FRONT_LINES  = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        enable_i,
   input  logic [1:0]  pattern_sel_i,
   output logic        VSYNC_o,
   output logic        HREF_HSYNC_o,
   output logic [7:0]  RGB_DAT_o,
   output logic        frame_done_o,
   output logic        busy_o,
   output logic [15:0] frame_cnt_o
);
   localparam int LINE_LEN = H_ACTIVE_BYTES + H_BLANK;
   localparam int HW       = $clog2(LINE_LEN);
   localparam int BAR_W    = H_ACTIVE_BYTES / 8;

   typedef enum logic [2:0] {IDLE, VSYNC, V_BACK, ACTIVE, V_FRONT} state_e;

   state_e          state_q, state_d;
   logic [HW-1:0]   h_cnt_q, h_cnt_d;
   logic [15:0]     l_cnt_q, l_cnt_d;
   logic [15:0]     act_q, act_d;
   logic [7:0]      ramp_q, ramp_d;
   logic [1:0]      sel_q, sel_d;
   logic [15:0]     fcnt_q, fcnt_d;
   logic            vsync_q, vsync_d, href_q, href_d, done_q, done_d, busy_q, busy_d;
   logic [7:0]      rgb_q, rgb_d;
   logic            line_end, act_byte, last, start;
   logic [7:0]      bar_idx, pattern;

   always_comb begin
      line_end = h_cnt_q == HW'(LINE_LEN - 1);
      act_byte = (state_q == ACTIVE) && (h_cnt_q < HW'(H_ACTIVE_BYTES));
      bar_idx  = 8'(h_cnt_q / HW'(BAR_W));
      pattern  = sel_q == 2'd0 ? ramp_q :
                 sel_q == 2'd1 ? 8'(bar_idx * 8'h24) :
                 sel_q == 2'd2 ? ((h_cnt_q[0] ^ act_q[0]) ? 8'h5A : 8'hA5) :
                                 act_q[7:0];
   end

   always_comb begin
      state_d = state_q;
      h_cnt_d = line_end ? '0 : h_cnt_q + 1'b1;
      l_cnt_d = l_cnt_q;
      act_d   = act_q;
      ramp_d  = act_byte ? ramp_q + 8'd1 : ramp_q;
      sel_d   = sel_q;
      fcnt_d  = fcnt_q;
      last    = 1'b0;
      start   = 1'b0;
      case (state_q)
         IDLE: begin
            h_cnt_d = '0;
            start   = enable_i;
         end
         VSYNC: if (line_end) begin
            l_cnt_d = l_cnt_q + 16'd1;
            if (l_cnt_q == 16'(VSYNC_LINES - 1)) begin
               l_cnt_d = '0;
               state_d = (V_BACK_LINES == 0) ? ACTIVE : V_BACK;
            end
         end
         V_BACK: if (line_end) begin
            l_cnt_d = l_cnt_q + 16'd1;
            if (l_cnt_q == 16'(V_BACK_LINES - 1)) begin
               l_cnt_d = '0;
               state_d = ACTIVE;
            end
         end
         ACTIVE: if (line_end) begin
            act_d = act_q + 16'd1;
            if (act_q == 16'(V_ACTIVE_LINES - 1)) begin
               act_d   = '0;
               state_d = V_FRONT;
            end
         end
         V_FRONT: if (line_end) begin
            l_cnt_d = l_cnt_q + 16'd1;
            if (l_cnt_q == 16'(V_FRONT_LINES - 1)) begin
               l_cnt_d = '0;
               last    = 1'b1;
               fcnt_d  = fcnt_q + 16'd1;
               state_d = IDLE;
               start   = enable_i;
            end
         end
         default: state_d = IDLE;
      endcase
      // Frame start: pattern select is captured only here, so mid-frame changes are ignored.
      if (start) begin
         state_d = VSYNC;
         sel_d   = pattern_sel_i;
         h_cnt_d = '0;
         l_cnt_d = '0;
         act_d   = '0;
         ramp_d  = '0;
      end
      vsync_d = state_q == VSYNC;
      href_d  = act_byte;
      rgb_d   = act_byte ? pattern : 8'h00;
      done_d  = last;
      busy_d  = state_q != IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         h_cnt_q <= '0;
         l_cnt_q <= '0;
         act_q   <= '0;
         ramp_q  <= '0;
         sel_q   <= '0;
         fcnt_q  <= '0;
         vsync_q <= 1'b0;
         href_q  <= 1'b0;
         rgb_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         h_cnt_q <= h_cnt_d;
         l_cnt_q <= l_cnt_d;
         act_q   <= act_d;
         ramp_q  <= ramp_d;
         sel_q   <= sel_d;
         fcnt_q  <= fcnt_d;
         vsync_q <= vsync_d;
         href_q  <= href_d;
         rgb_q   <= rgb_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign VSYNC_o      = vsync_q;
   assign HREF_HSYNC_o = href_q;
   assign RGB_DAT_o    = rgb_q;
   assign frame_done_o = done_q;
   assign busy_o       = busy_q;
   assign frame_cnt_o  = fcnt_q;
endmodule

// File: tb/tb_vga_test_pattern_gen.sv
// tb_vga_test_pattern_gen: frame-level scoreboard bench; each frame's expected per-cycle outputs are queued at start.
module tb_vga_test_pattern_gen;
   localparam int HA = 8, HB = 4, VA = 3, VS = 1, VB = 1, VF = 1;
   localparam int LL = HA + HB;
   localparam int FR = (VS + VB + VA + VF) * LL;

   logic        clk = 1'b0, rst, en;
   logic [1:0]  sel;
   logic        vs_o, hr_o, done_o, busy_o;
   logic [7:0]  rgb_o;
   logic [15:0] fc_o;

   vga_test_pattern_gen #(
      .H_ACTIVE_BYTES(HA), .H_BLANK(HB), .V_ACTIVE_LINES(VA),
      .VSYNC_LINES(VS), .V_BACK_LINES(VB), .V_FRONT_LINES(VF)
   ) dut (
      .clk_i(clk), .rst_i(rst), .enable_i(en), .pattern_sel_i(sel),
      .VSYNC_o(vs_o), .HREF_HSYNC_o(hr_o), .RGB_DAT_o(rgb_o),
      .frame_done_o(done_o), .busy_o(busy_o), .frame_cnt_o(fc_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        vs;
      logic        hr;
      logic [7:0]  rgb;
      logic        done;
      logic        busy;
      logic [15:0] fc;
   } obs_t;

   typedef struct {
      logic       idle_in;
      logic [1:0] s;
      int         set_at;
      logic       en_n;
      logic [1:0] sel_n;
      int         n;
   } vec_t;

   obs_t        q[$];
   vec_t        tab[10];
   logic [7:0]  bars[8];
   logic [15:0] fc_exp = '0;
   int          checks = 0, errors = 0;

   function automatic logic [7:0] pat(logic [1:0] s, int line, int b);
      case (s)
         2'd0:    return 8'(line * HA + b);
         2'd1:    return bars[b];
         2'd2:    return (((b ^ line) & 1) != 0) ? 8'h5A : 8'hA5;
         default: return 8'(line);
      endcase
   endfunction

   function automatic obs_t idle_obs();
      return {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, fc_exp};
   endfunction

   task automatic check(string name, obs_t e);
      obs_t a;
      a = {vs_o, hr_o, rgb_o, done_o, busy_o, fc_o};
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s @%0t: got vs=%b hr=%b rgb=%h done=%b busy=%b fc=%0d, expected vs=%b hr=%b rgb=%h done=%b busy=%b fc=%0d",
                  name, $time, a.vs, a.hr, a.rgb, a.done, a.busy, a.fc, e.vs, e.hr, e.rgb, e.done, e.busy, e.fc);
      end
   endtask

   task automatic push_frame(logic [1:0] s);
      for (int c = 0; c < FR; c++) begin
         obs_t e;
         int k, line, b;
         k    = c - (VS + VB) * LL;
         line = k / LL;
         b    = k % LL;
         e.vs   = c < VS * LL;
         e.hr   = (k >= 0) && (k < VA * LL) && (b < HA);
         e.rgb  = e.hr ? pat(s, line, b) : 8'h00;
         e.done = c == FR - 1;
         e.busy = 1'b1;
         if (e.done) fc_exp++;
         e.fc = fc_exp;
         q.push_back(e);
      end
   endtask

   task automatic step_idle(string name);
      @(posedge clk);
      @(negedge clk);
      check(name, idle_obs());
   endtask

   task automatic run_vec(vec_t v);
      if (v.idle_in) step_idle("lead_in");
      push_frame(v.s);
      for (int c = 0; c < v.n; c++) begin
         if (c == v.set_at) begin
            en  = v.en_n;
            sel = v.sel_n;
         end
         @(posedge clk);
         @(negedge clk);
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame: scoreboard empty at cycle %0d", c);
         end else check($sformatf("frame_sel%0d_c%0d", v.s, c), q.pop_front());
      end
   endtask

   initial begin
      bars[0] = 8'h00; bars[1] = 8'h24; bars[2] = 8'h48; bars[3] = 8'h6C;
      bars[4] = 8'h90; bars[5] = 8'hB4; bars[6] = 8'hD8; bars[7] = 8'hFC;
      // idle_in, latched sel, drive-at cycle, enable next, sel next, cycles run
      tab[0] = '{1'b1, 2'd0, 5,  1'b1, 2'd1, FR};
      tab[1] = '{1'b0, 2'd1, 5,  1'b1, 2'd2, FR};
      tab[2] = '{1'b0, 2'd2, 5,  1'b1, 2'd3, FR};
      tab[3] = '{1'b0, 2'd3, 5,  1'b1, 2'd0, FR};
      tab[4] = '{1'b0, 2'd0, 30, 1'b0, 2'd1, FR};
      tab[5] = '{1'b1, 2'd0, 5,  1'b1, 2'd0, FR};
      tab[6] = '{1'b0, 2'd0, 5,  1'b1, 2'd0, FR};
      tab[7] = '{1'b0, 2'd0, 40, 1'b1, 2'd0, FR};
      tab[8] = '{1'b0, 2'd0, 99, 1'b1, 2'd0, 40};
      tab[9] = '{1'b1, 2'd2, 10, 1'b0, 2'd1, FR};

      rst = 1'b1; en = 1'b0; sel = 2'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset", idle_obs());
      rst = 1'b0; en = 1'b1; sel = 2'd0;
      for (int i = 0; i < 5; i++) run_vec(tab[i]);
      for (int i = 0; i < 4; i++) step_idle("idle_after_drop");
      en = 1'b1; sel = 2'd0;
      for (int i = 5; i < 9; i++) run_vec(tab[i]);
      // Reset lands in active line 1 of a partly-checked frame.
      rst = 1'b1;
      q.delete();
      fc_exp = '0;
      step_idle("rst_mid_frame");
      rst = 1'b0; en = 1'b1; sel = 2'd2;
      run_vec(tab[9]);
      for (int i = 0; i < 4; i++) step_idle("idle_final");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
